// File: rtl/buffer_pkg.sv
// Shared types and default sizing for the multichannel buffer write side.
package buffer_pkg;

    localparam int PTR_WIDTH_DEF    = 10;
    localparam int DATA_WIDTH_DEF   = 64;
    localparam int NUM_CHANNELS_DEF = 8;
    localparam int FL_RD_LAT_DEF    = 1;

    // Pointers held locally in front of the free list.
    localparam int PREFETCH_DEPTH   = 2;

    typedef logic [PTR_WIDTH_DEF-1:0] ptr_t;

    // Descriptor handed to the per-channel queue stage.
    typedef struct packed {
        ptr_t ptr;
        logic last;
    } desc_t;

    typedef enum logic [0:0] {
        WAIT_INIT = 1'b0,
        RUN       = 1'b1
    } alloc_state_e;

endpackage

// File: rtl/buffer_write_alloc_ptr_prefetch.sv
// Two-entry free-pointer prefetch: tracks pops in flight through the free-list
// read pipeline, stores returned pointers in arrival order and presents the
// oldest one. A pointer arriving in the same cycle it is needed bypasses the
// storage, which keeps one allocation per cycle for both read latencies.
module ptr_prefetch
    import buffer_pkg::*;
#(
    parameter int PTR_WIDTH = PTR_WIDTH_DEF,
    parameter int FL_RD_LAT = FL_RD_LAT_DEF
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 run,
    input  logic                 pop,
    input  logic                 fl_empty,
    input  logic [PTR_WIDTH-1:0] fl_rd_dout,
    output logic                 fl_rd_req,
    output logic                 avail,
    output logic [PTR_WIDTH-1:0] head,
    output logic                 busy
);

    logic [FL_RD_LAT-1:0] vld_sr;
    logic                 capture;
    logic [1:0]           occ;
    logic [1:0]           occ_mid;
    logic [1:0]           occ_n;
    logic [1:0]           inf;
    logic                 pop_stored;
    logic                 store;
    logic [PTR_WIDTH-1:0] entry   [PREFETCH_DEPTH];
    logic [PTR_WIDTH-1:0] entry_n [PREFETCH_DEPTH];

    // The oldest request's pointer is on fl_rd_dout when its valid bit leaves the pipe.
    assign capture = vld_sr[FL_RD_LAT-1];

    // Count requests whose pointer has not been captured yet.
    always_comb begin
        // NOTE: every variable written in a combinational block gets a value first, otherwise a latch is inferred.
        inf = '0;
        for (int i = 0; i < FL_RD_LAT; i++) begin
            inf = inf + {1'b0, vld_sr[i]};
        end
    end

    // Pop the free list while stored + in-flight pointers, net of this cycle's use, leave room.
    assign fl_rd_req = run & ~fl_empty &
                       (({1'b0, occ} + {1'b0, inf}) < (3'(PREFETCH_DEPTH) + {2'b0, pop}));

    assign avail = (occ != 2'd0) | capture;
    assign head  = (occ != 2'd0) ? entry[0] : fl_rd_dout;
    assign busy  = (occ != 2'd0) | (inf != 2'd0);

    // Next storage contents: drop the head on a stored pop, append an arrival behind the survivors.
    always_comb begin
        pop_stored = pop & (occ != 2'd0);
        store      = capture & ~(pop & (occ == 2'd0));
        occ_mid    = occ - {1'b0, pop_stored};
        entry_n    = entry;
        if (pop_stored) begin
            entry_n[0] = entry[1];
        end
        if (store) begin
            entry_n[occ_mid[0]] = fl_rd_dout;
        end
        occ_n = occ_mid + {1'b0, store};
    end

    // In-flight valid pipeline, one stage per cycle of free-list read latency.
    if (FL_RD_LAT == 1) begin : g_lat1
        always_ff @(posedge clk) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            if (!rstn) vld_sr <= '0;
            else       vld_sr <= fl_rd_req;
        end
    end else begin : g_latn
        always_ff @(posedge clk) begin
            if (!rstn) vld_sr <= '0;
            else       vld_sr <= {vld_sr[FL_RD_LAT-2:0], fl_rd_req};
        end
    end

    // Occupancy register; reset discards everything held or in flight.
    always_ff @(posedge clk) begin
        if (!rstn) occ <= 2'd0;
        else       occ <= occ_n;
    end

    // Pointer storage.
    always_ff @(posedge clk) begin
        // NOTE: pointer storage is not reset; occupancy says which entries are meaningful.
        entry <= entry_n;
    end

endmodule

// File: rtl/buffer_write_alloc.sv
// Write-side allocator: waits for the free list to initialise, accepts input
// beats while a free pointer is available and the target queue has room, and
// issues the cell write and queue descriptor together one cycle later.
module buffer_write_alloc
    import buffer_pkg::*;
#(
    parameter int PTR_WIDTH    = PTR_WIDTH_DEF,
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int NUM_CHANNELS = NUM_CHANNELS_DEF,
    parameter int FL_RD_LAT    = FL_RD_LAT_DEF
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [DATA_WIDTH-1:0]           s_data,
    input  logic                            s_last,
    input  logic [$clog2(NUM_CHANNELS)-1:0] s_chan,
    output logic                            fl_rd_req,
    input  logic [PTR_WIDTH-1:0]            fl_rd_dout,
    input  logic                            fl_empty,
    input  logic                            fl_init_done,
    output logic                            mem_we,
    output logic [PTR_WIDTH-1:0]            mem_waddr,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    output logic                            q_push,
    output logic [$clog2(NUM_CHANNELS)-1:0] q_chan,
    output logic [PTR_WIDTH-1:0]            q_ptr,
    output logic                            q_last,
    input  logic [NUM_CHANNELS-1:0]         q_afull,
    output logic                            busy
);

    alloc_state_e         state;
    alloc_state_e         state_n;
    logic                 run;
    logic                 avail;
    logic                 accept;
    logic [PTR_WIDTH-1:0] head;

    // State register; only reset returns the allocator to WAIT_INIT.
    always_ff @(posedge clk) begin
        if (!rstn) state <= WAIT_INIT;
        else       state <= state_n;
    end

    // Next state: leave WAIT_INIT once the free list reports it is initialised.
    always_comb begin
        state_n = state;
        case (state)
            WAIT_INIT: if (fl_init_done) state_n = RUN;
            RUN:       state_n = RUN;
            default:   state_n = WAIT_INIT;
        endcase
    end

    assign run = (state == RUN);

    // A beat is taken only with a pointer in hand and room in its own queue.
    assign s_ready = run & avail & ~q_afull[s_chan];
    assign accept  = s_valid & s_ready;

    ptr_prefetch #(
        .PTR_WIDTH (PTR_WIDTH),
        .FL_RD_LAT (FL_RD_LAT)
    ) u_prefetch (
        .clk        (clk),
        .rstn       (rstn),
        .run        (run),
        .pop        (accept),
        .fl_empty   (fl_empty),
        .fl_rd_dout (fl_rd_dout),
        .fl_rd_req  (fl_rd_req),
        .avail      (avail),
        .head       (head),
        .busy       (busy)
    );

    // Output stage: cell write and descriptor push leave together, one cycle after accept.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mem_we    <= 1'b0;
            q_push    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            q_chan    <= '0;
            q_ptr     <= '0;
            q_last    <= 1'b0;
        end else begin
            mem_we <= accept;
            q_push <= accept;
            if (accept) begin
                mem_waddr <= head;
                mem_wdata <= s_data;
                q_chan    <= s_chan;
                q_ptr     <= head;
                q_last    <= s_last;
            end
        end
    end

    // The free list must stay initialised for as long as the allocator runs.
    a_init_held: assert property (@(posedge clk) disable iff (!rstn) (state == RUN) |-> fl_init_done);

endmodule
